z80_sequencer: RTL and testbench

- Control initiator for the z80 register file. It fetches opcode bytes from data_bus at addr_bus, the PC-driven address.
- It decodes a Z80 subset: NOP, LD r,n, LD r,r', 8-bit ALU A,r, and HALT.
- It drives the register file's WE, alu_ld_r and alu_re_r controls, the ALU operation select, and a PC advance enable (pc_inc), which is wired to the PC write enable.
- Memory reads are combinational: data_bus is valid in the same cycle as addr_bus.

---
 rtl/z80_pkg.sv | 88 ++++++++
 rtl/z80_decode.sv | 68 ++++++
 rtl/z80_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_z80_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_pkg.sv
// Shared types, constants and register-code mapping helpers for the z80 sequencer.
package z80_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    IMM    = 3'd1,
    ALU_OP = 3'd2,
    ALU_WB = 3'd3,
    HALT   = 3'd4
  } state_e;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_IMM  = 3'd1,
    KIND_ALU  = 3'd2,
    KIND_HALT = 3'd3,
    KIND_ILL  = 3'd4
  } kind_e;

  // ALU operation select values.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADC  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SBC  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_CP   = 4'd7;
  localparam logic [3:0] ALU_PASS = 4'd8;

  // Z80 register codes with special meaning.
  localparam logic [2:0] REG_A      = 3'b111;
  localparam logic [2:0] REG_HL_IND = 3'b110;

  // alu_ld_r bit for the flag register.
  localparam logic [7:0] LD_F_MASK = 8'h80;

  // Register-file read index for a Z80 register code; (HL) maps to 0.
  function automatic logic [3:0] reg_re_idx(input logic [2:0] code);
    logic [3:0] idx;
    case (code)
      3'b000:  idx = 4'd2;
      3'b001:  idx = 4'd3;
      3'b010:  idx = 4'd4;
      3'b011:  idx = 4'd5;
      3'b100:  idx = 4'd6;
      3'b101:  idx = 4'd7;
      3'b111:  idx = 4'd0;
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

  // One-hot register write enable for a Z80 register code; (HL) gives none.
  function automatic logic [15:0] reg_we_mask(input logic [2:0] code);
    logic [15:0] mask;
    case (code)
      3'b000:  mask = 16'h0010;
      3'b001:  mask = 16'h0020;
      3'b010:  mask = 16'h0040;
      3'b011:  mask = 16'h0080;
      3'b100:  mask = 16'h0100;
      3'b101:  mask = 16'h0200;
      3'b111:  mask = 16'h0004;
      default: mask = 16'h0000;
    endcase
    return mask;
  endfunction

  // One-hot ALU-result load for a Z80 register code; (HL) gives none.
  function automatic logic [7:0] reg_ld_mask(input logic [2:0] code);
    logic [7:0] mask;
    case (code)
      3'b000:  mask = 8'h02;
      3'b001:  mask = 8'h04;
      3'b010:  mask = 8'h08;
      3'b011:  mask = 8'h10;
      3'b100:  mask = 8'h20;
      3'b101:  mask = 8'h40;
      3'b111:  mask = 8'h01;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/z80_decode.sv
// Combinational opcode classifier for the supported Z80 subset.
module z80_decode
  import z80_pkg::*;
#(
  parameter bit HALT_EN = 1'b1
) (
  input  logic [7:0] opcode_i,
  output kind_e      kind_o,
  output logic [2:0] dst_o,
  output logic [2:0] src_o,
  output logic [3:0] op_o,
  output logic       flag_wr_o,
  output logic       illegal_o
);

  // Classify the opcode and extract operand fields.
  always_comb begin
    kind_o    = KIND_ILL;
    dst_o     = 3'd0;
    src_o     = opcode_i[2:0];
    op_o      = ALU_PASS;
    flag_wr_o = 1'b0;
    if (opcode_i == 8'h00) begin
      kind_o = KIND_NOP;
    end else if (opcode_i == 8'h76) begin
      if (HALT_EN) begin
        kind_o = KIND_HALT;
      end else begin
        kind_o = KIND_NOP;
      end
    end else begin
      case (opcode_i[7:6])
        2'b00: begin
          // LD r,n: 00ddd110 with a real destination register
          if ((opcode_i[2:0] == REG_HL_IND) && (opcode_i[5:3] != REG_HL_IND)) begin
            kind_o = KIND_IMM;
            dst_o  = opcode_i[5:3];
          end else begin
            kind_o = KIND_ILL;
          end
        end
        2'b01: begin
          // LD r,r': routed through the ALU as a pass-through
          if ((opcode_i[5:3] != REG_HL_IND) && (opcode_i[2:0] != REG_HL_IND)) begin
            kind_o = KIND_ALU;
            dst_o  = opcode_i[5:3];
          end else begin
            kind_o = KIND_ILL;
          end
        end
        2'b10: begin
          // 8-bit ALU A,r: result to A, flags always written
          if (opcode_i[2:0] != REG_HL_IND) begin
            kind_o    = KIND_ALU;
            dst_o     = REG_A;
            op_o      = {1'b0, opcode_i[5:3]};
            flag_wr_o = 1'b1;
          end else begin
            kind_o = KIND_ILL;
          end
        end
        default: kind_o = KIND_ILL;
      endcase
    end
    illegal_o = (kind_o == KIND_ILL);
  end

endmodule

// File: rtl/z80_sequencer.sv
// Fetch/decode/execute control sequencer driving the z80 register file and ALU.
// All outputs are registered and derived from the state being entered, so
// data_bus never reaches an output combinationally.
module z80_sequencer
  import z80_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter bit HALT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         data_bus,
  output logic [15:0]        WE,
  output logic [7:0]         alu_ld_r,
  output logic [3:0]         alu_re_r,
  output logic [3:0]         alu_op,
  output logic               pc_inc,
  output logic               halted,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  kind_e        dec_kind;
  logic [2:0]   dec_dst;
  logic [2:0]   dec_src;
  logic [3:0]   dec_op;
  logic         dec_flag_wr;
  logic         dec_illegal;

  state_e       state_q, state_d;
  logic [2:0]   dst_q, dst_d;
  logic [3:0]   op_q, op_d;
  logic         flag_q, flag_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [15:0]  we_q, we_d;
  logic [7:0]   ld_q, ld_d;
  logic [3:0]   re_q, re_d;
  logic [3:0]   aluop_q, aluop_d;
  logic         pc_inc_q, pc_inc_d;
  logic         halted_q, halted_d;
  logic         illegal_q, illegal_d;
  logic [2:0]   src_s;
  logic         retire_s;

  z80_decode #(
    .HALT_EN (HALT_EN)
  ) u_decode (
    .opcode_i  (data_bus),
    .kind_o    (dec_kind),
    .dst_o     (dec_dst),
    .src_o     (dec_src),
    .op_o      (dec_op),
    .flag_wr_o (dec_flag_wr),
    .illegal_o (dec_illegal)
  );

  // Next state, latched instruction fields, retire count and the controls of the entered state.
  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    op_d      = op_q;
    flag_d    = flag_q;
    src_s     = 3'd0;
    retire_s  = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      FETCH: begin
        src_s     = dec_src;
        illegal_d = dec_illegal;
        case (dec_kind)
          KIND_NOP: begin
            state_d  = FETCH;
            retire_s = 1'b1;
          end
          KIND_HALT: begin
            state_d  = HALT;
            retire_s = 1'b1;
          end
          KIND_IMM: begin
            state_d = IMM;
            dst_d   = dec_dst;
          end
          KIND_ALU: begin
            state_d = ALU_OP;
            dst_d   = dec_dst;
            op_d    = dec_op;
            flag_d  = dec_flag_wr;
          end
          default: begin
            // unsupported opcode: retired as a NOP, flagged next cycle
            state_d  = FETCH;
            retire_s = 1'b1;
          end
        endcase
      end
      IMM: begin
        state_d  = FETCH;
        retire_s = 1'b1;
      end
      ALU_OP: begin
        state_d = ALU_WB;
      end
      ALU_WB: begin
        state_d  = FETCH;
        retire_s = 1'b1;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (retire_s) begin
      count_d = count_q + COUNT_W'(1);
    end else begin
      count_d = count_q;
    end

    we_d     = 16'h0000;
    ld_d     = 8'h00;
    re_d     = 4'd0;
    aluop_d  = 4'd0;
    pc_inc_d = 1'b0;
    halted_d = 1'b0;
    case (state_d)
      FETCH: begin
        pc_inc_d = 1'b1;
      end
      IMM: begin
        pc_inc_d = 1'b1;
        we_d     = reg_we_mask(dst_d);
      end
      ALU_OP: begin
        re_d    = reg_re_idx(src_s);
        aluop_d = op_d;
      end
      ALU_WB: begin
        aluop_d = op_d;
        // CP only updates flags, never the accumulator
        if (op_d == ALU_CP) begin
          ld_d = 8'h00;
        end else begin
          ld_d = reg_ld_mask(dst_d);
        end
        if (flag_d) begin
          ld_d = ld_d | LD_F_MASK;
        end else begin
          ld_d = ld_d;
        end
      end
      HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        pc_inc_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      dst_q     <= 3'd0;
      op_q      <= ALU_ADD;
      flag_q    <= 1'b0;
      count_q   <= {COUNT_W{1'b0}};
      we_q      <= 16'h0000;
      ld_q      <= 8'h00;
      re_q      <= 4'd0;
      aluop_q   <= 4'd0;
      pc_inc_q  <= 1'b1;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      op_q      <= op_d;
      flag_q    <= flag_d;
      count_q   <= count_d;
      we_q      <= we_d;
      ld_q      <= ld_d;
      re_q      <= re_d;
      aluop_q   <= aluop_d;
      pc_inc_q  <= pc_inc_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign WE          = we_q;
  assign alu_ld_r    = ld_q;
  assign alu_re_r    = re_q;
  assign alu_op      = aluop_q;
  assign pc_inc      = pc_inc_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_z80_sequencer.sv
// Self-checking bench for z80_sequencer: directed scenarios plus random opcode
// streams checked against a cycle-level model of the instruction set.
module tb_z80_sequencer;

  localparam int CW = 4;
  localparam int CMOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data_bus;
  logic [15:0]   WE;
  logic [7:0]    alu_ld_r;
  logic [3:0]    alu_re_r;
  logic [3:0]    alu_op;
  logic          pc_inc;
  logic          halted;
  logic          illegal;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  bit exp_ill = 1'b0;

  // Register-code lookup tables: read index, WE bit, alu_ld_r bit (code 6 unused).
  int re_tab [8] = '{2, 3, 4, 5, 6, 7, 0, 0};
  int we_tab [8] = '{4, 5, 6, 7, 8, 9, 0, 2};
  int ld_tab [8] = '{1, 2, 3, 4, 5, 6, 0, 0};

  z80_sequencer #(
    .COUNT_W (CW),
    .HALT_EN (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_bus    (data_bus),
    .WE          (WE),
    .alu_ld_r    (alu_ld_r),
    .alu_re_r    (alu_re_r),
    .alu_op      (alu_op),
    .pc_inc      (pc_inc),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Structural invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if ((WE !== 16'h0000 && alu_ld_r !== 8'h00) || $countones(WE) > 1) begin
        errors++;
        $display("FAIL invariant WE=%h alu_ld_r=%h (WE one-hot or zero, not both nonzero)", WE, alu_ld_r);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Execute one instruction from a FETCH cycle, checking every cycle against the model.
  task automatic run_instr(input logic [7:0] opc, input logic [7:0] imm);
    logic [1:0]  hi;
    logic [2:0]  mid, lo;
    int          dst;
    logic [3:0]  eop;
    bit          flag;
    logic [7:0]  eld;
    logic [15:0] ewe;
    hi  = opc[7:6];
    mid = opc[5:3];
    lo  = opc[2:0];
    checks++;
    if (pc_inc !== 1'b1 || WE !== 16'h0000 || alu_ld_r !== 8'h00 || alu_re_r !== 4'd0 ||
        alu_op !== 4'd0 || halted !== 1'b0 || illegal !== exp_ill || instr_count !== CW'(exp_count)) begin
      errors++;
      $display("FAIL fetch before op=%h: pc=%b WE=%h ld=%h re=%0d aop=%0d h=%b il=%b cnt=%0d, want pc=1 zeros il=%b cnt=%0d",
               opc, pc_inc, WE, alu_ld_r, alu_re_r, alu_op, halted, illegal, instr_count, exp_ill, exp_count);
    end
    exp_ill = 1'b0;
    data_bus = opc;
    step();
    if (opc == 8'h00 || opc == 8'h76) begin
      exp_count = (exp_count + 1) % CMOD;
    end else if (hi == 2'd0 && lo == 3'd6 && mid != 3'd6) begin
      ewe = 16'h0001 << we_tab[mid];
      checks++;
      if (WE !== ewe || pc_inc !== 1'b1 || alu_ld_r !== 8'h00 || halted !== 1'b0 ||
          illegal !== 1'b0 || instr_count !== CW'(exp_count)) begin
        errors++;
        $display("FAIL imm op=%h: WE=%h pc=%b ld=%h cnt=%0d, want WE=%h pc=1 ld=0 cnt=%0d",
                 opc, WE, pc_inc, alu_ld_r, instr_count, ewe, exp_count);
      end
      data_bus = imm;
      step();
      exp_count = (exp_count + 1) % CMOD;
    end else if ((hi == 2'd1 && mid != 3'd6 && lo != 3'd6) || (hi == 2'd2 && lo != 3'd6)) begin
      if (hi == 2'd1) begin
        dst = int'(mid); eop = 4'd8; flag = 1'b0;
      end else begin
        dst = 7; eop = {1'b0, mid}; flag = 1'b1;
      end
      checks++;
      if (alu_re_r !== 4'(re_tab[lo]) || alu_op !== eop || pc_inc !== 1'b0 || WE !== 16'h0000 ||
          alu_ld_r !== 8'h00 || halted !== 1'b0 || instr_count !== CW'(exp_count)) begin
        errors++;
        $display("FAIL alu_op op=%h: re=%0d aop=%0d pc=%b WE=%h ld=%h cnt=%0d, want re=%0d aop=%0d pc=0 cnt=%0d",
                 opc, alu_re_r, alu_op, pc_inc, WE, alu_ld_r, instr_count, re_tab[lo], eop, exp_count);
      end
      data_bus = 8'($urandom);
      step();
      eld = (eop == 4'd7) ? 8'h00 : (8'h01 << ld_tab[dst]);
      if (flag) eld = eld | 8'h80;
      checks++;
      if (alu_ld_r !== eld || alu_op !== eop || pc_inc !== 1'b0 || WE !== 16'h0000 ||
          halted !== 1'b0 || instr_count !== CW'(exp_count)) begin
        errors++;
        $display("FAIL alu_wb op=%h: ld=%h aop=%0d pc=%b WE=%h cnt=%0d, want ld=%h aop=%0d pc=0 cnt=%0d",
                 opc, alu_ld_r, alu_op, pc_inc, WE, instr_count, eld, eop, exp_count);
      end
      data_bus = 8'($urandom);
      step();
      exp_count = (exp_count + 1) % CMOD;
    end else begin
      exp_count = (exp_count + 1) % CMOD;
      exp_ill   = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    data_bus = 8'hFF;
    step();
    step();
    checks++;
    if (WE !== 16'h0000 || alu_ld_r !== 8'h00 || pc_inc !== 1'b1 || instr_count !== 4'd0 ||
        halted !== 1'b0 || illegal !== 1'b0 || alu_re_r !== 4'd0 || alu_op !== 4'd0) begin
      errors++;
      $display("FAIL reset: WE=%h ld=%h pc=%b cnt=%0d h=%b il=%b re=%0d aop=%0d, want pc=1 rest 0",
               WE, alu_ld_r, pc_inc, instr_count, halted, illegal, alu_re_r, alu_op);
    end
    reset     = 1'b1;
    exp_count = 0;
    exp_ill   = 1'b0;
  endtask

  task automatic test_ld_imm();
    run_instr(8'h06, 8'h5A);
    run_instr(8'h3E, 8'hC3);
    run_instr(8'h2E, 8'h76);
  endtask

  task automatic test_alu_add();
    run_instr(8'h80, 8'h00);
    run_instr(8'h97, 8'h00);
  endtask

  task automatic test_cp_move();
    run_instr(8'hB9, 8'h00);
    run_instr(8'h78, 8'h00);
    run_instr(8'h45, 8'h00);
  endtask

  task automatic test_illegal();
    run_instr(8'h36, 8'h00);
    run_instr(8'h46, 8'h00);
    run_instr(8'h00, 8'h00);
    run_instr(8'hC3, 8'h00);
    run_instr(8'h86, 8'h00);
    run_instr(8'h00, 8'h00);
  endtask

  task automatic test_halt();
    run_instr(8'h76, 8'h00);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (halted !== 1'b1 || pc_inc !== 1'b0 || WE !== 16'h0000 || alu_ld_r !== 8'h00 ||
          alu_re_r !== 4'd0 || alu_op !== 4'd0 || instr_count !== CW'(exp_count)) begin
        errors++;
        $display("FAIL halt cycle %0d: h=%b pc=%b WE=%h ld=%h cnt=%0d, want h=1 pc=0 zeros cnt=%0d",
                 i, halted, pc_inc, WE, alu_ld_r, instr_count, exp_count);
      end
      data_bus = 8'($urandom);
      step();
    end
    reset = 1'b0;
    step();
    checks++;
    if (halted !== 1'b0 || pc_inc !== 1'b1 || instr_count !== 4'd0) begin
      errors++;
      $display("FAIL halt_exit: h=%b pc=%b cnt=%0d, want h=0 pc=1 cnt=0", halted, pc_inc, instr_count);
    end
    reset     = 1'b1;
    exp_count = 0;
    exp_ill   = 1'b0;
    run_instr(8'h00, 8'h00);
  endtask

  task automatic test_reset_mid();
    data_bus = 8'h80;
    step();
    checks++;
    if (pc_inc !== 1'b0 || alu_re_r !== 4'd2) begin
      errors++;
      $display("FAIL mid_alu_entry: pc=%b re=%0d, want pc=0 re=2", pc_inc, alu_re_r);
    end
    reset = 1'b0;
    step();
    checks++;
    if (WE !== 16'h0000 || alu_ld_r !== 8'h00 || pc_inc !== 1'b1 || instr_count !== 4'd0 || alu_op !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_alu: WE=%h ld=%h pc=%b cnt=%0d aop=%0d, want WE=0 ld=0 pc=1 cnt=0 aop=0",
               WE, alu_ld_r, pc_inc, instr_count, alu_op);
    end
    reset     = 1'b1;
    exp_count = 0;
    exp_ill   = 1'b0;
    run_instr(8'h00, 8'h00);
    data_bus = 8'h06;
    step();
    reset    = 1'b0;
    data_bus = 8'h00;
    step();
    checks++;
    if (WE !== 16'h0000 || pc_inc !== 1'b1 || instr_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_imm: WE=%h pc=%b cnt=%0d, want WE=0 pc=1 cnt=0", WE, pc_inc, instr_count);
    end
    reset     = 1'b1;
    exp_count = 0;
    exp_ill   = 1'b0;
    run_instr(8'h00, 8'h00);
    run_instr(8'h0E, 8'h11);
  endtask

  task automatic test_count_wrap();
    reset = 1'b0;
    step();
    reset     = 1'b1;
    exp_count = 0;
    exp_ill   = 1'b0;
    for (int i = 0; i < 17; i++) begin
      run_instr(8'h00, 8'h00);
    end
    checks++;
    if (instr_count !== 4'd1) begin
      errors++;
      $display("FAIL count_wrap: instr_count=%0d, want 1 after 17 NOPs", instr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] opc;
    for (int i = 0; i < 300; i++) begin
      opc = 8'($urandom_range(0, 255));
      if (opc == 8'h76) opc = 8'h00;
      run_instr(opc, 8'($urandom));
    end
    run_instr(8'h00, 8'h00);
  endtask

  initial begin
    reset    = 1'b0;
    data_bus = 8'h00;
    test_reset();
    test_ld_imm();
    test_alu_add();
    test_cp_move();
    test_illegal();
    test_halt();
    test_reset_mid();
    test_count_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
